// File: rtl/mem_responder.sv
// mem_responder
//   Byte-wide memory/IO responder behind the CPU memory bus. Serves one byte
//   per cycle from a synchronous RAM (one-cycle read latency) and decodes a
//   small IO window at cpu_a[17:16] == 2'b11:
//     0x30000  read: pop host->CPU FIFO (0x00 if empty)
//              write: push CPU->host FIFO (dropped and flagged if full)
//     0x30004  read: {6'b0, tx_full, rx_nonempty}
//              write: latch program-end flag and code (first write only)
//   A loader port can preload the RAM; it takes priority over the CPU.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   cpu_a, cpu_wr, cpu_wdata        CPU access (every cycle is an access)
//   cpu_rdata                       registered read byte
//   io_buffer_full                  output FIFO nearly full
//   load_we, load_addr, load_data   RAM loader
//   rx_valid, rx_data, rx_ready     host -> CPU byte stream
//   tx_valid, tx_data, tx_ready     CPU -> host byte stream
//   prog_end, prog_code             sticky end-of-program flag and code
//   tx_overflow                     sticky dropped-write flag
module mem_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpu_a,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  io_buffer_full,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_data,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  prog_end,
  output logic [7:0]            prog_code,
  output logic                  tx_overflow
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int RAM_SIZE = 1 << ADDR_WIDTH;

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH - FULL_MARGIN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [15:0]      OFF_DATA   = 16'h0000;
  localparam logic [15:0]      OFF_CTRL   = 16'h0004;

  logic [7:0] ram [RAM_SIZE];

  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_rptr, rx_wptr;
  logic [CNT_W-1:0] rx_count;

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_rptr, tx_wptr;
  logic [CNT_W-1:0] tx_count;

  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  is_io, sel_data, sel_ctrl;
  logic                  cpu_active;
  logic                  ram_wr;
  logic                  rx_nonempty, tx_full;
  logic                  rx_push, rx_pop;
  logic                  tx_push_req, tx_push, tx_pop;
  logic                  prog_wr;
  logic [7:0]            io_read_byte;

  // Address bits above the decode field do not take part in decoding; the
  // RAM and the IO window alias across them.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_a[31:18];

  assign ram_idx  = cpu_a[ADDR_WIDTH-1:0];
  assign is_io    = (cpu_a[17:16] == 2'b11);
  assign sel_data = is_io && (cpu_a[15:0] == OFF_DATA);
  assign sel_ctrl = is_io && (cpu_a[15:0] == OFF_CTRL);

  // A loader write or reset steals the cycle from the CPU entirely.
  assign cpu_active = !rst && !load_we;

  assign rx_nonempty = (rx_count != '0);
  assign tx_full     = (tx_count == DEPTH_CNT);

  assign rx_ready       = (rx_count != DEPTH_CNT);
  assign tx_valid       = (tx_count != '0);
  assign tx_data        = tx_mem[tx_rptr];
  assign io_buffer_full = (tx_count >= FULL_LEVEL);

  // Handshakes are suppressed in the reset cycle so nothing is half-taken.
  assign rx_push     = !rst && rx_valid && rx_ready;
  assign rx_pop      = cpu_active && !cpu_wr && sel_data && rx_nonempty;
  assign tx_push_req = cpu_active && cpu_wr && sel_data;
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !rst && tx_valid && tx_ready;
  assign ram_wr      = cpu_active && cpu_wr && !is_io;
  assign prog_wr     = cpu_active && cpu_wr && sel_ctrl && !prog_end;

  // RAM write port; contents survive reset, and the loader still commits
  // during the reset cycle.
  always_ff @(posedge clk) begin
    if (load_we) begin
      ram[load_addr] <= load_data;
    end else if (ram_wr) begin
      ram[ram_idx] <= cpu_wdata;
    end
  end

  // IO read data is built from pre-edge FIFO state.
  always_comb begin
    io_read_byte = 8'h00;
    if (sel_data) begin
      io_read_byte = rx_nonempty ? rx_mem[rx_rptr] : 8'h00;
    end else if (sel_ctrl) begin
      io_read_byte = {6'b0, tx_full, rx_nonempty};
    end
  end

  // Read data register: holds across loader cycles, zero on any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata <= 8'h00;
    end else if (!load_we) begin
      if (cpu_wr) begin
        cpu_rdata <= 8'h00;
      end else if (!is_io) begin
        cpu_rdata <= ram[ram_idx];
      end else begin
        cpu_rdata <= io_read_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rptr  <= '0;
      rx_wptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr] <= cpu_wdata;
    end
  end

  // A write to a full output FIFO is dropped even if the host pops in the
  // same cycle; fullness is judged on the pre-edge count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rptr     <= '0;
      tx_wptr     <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
      if (tx_push_req && tx_full) tx_overflow <= 1'b1;
    end
  end

  // Only the first end-of-program write is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_end  <= 1'b0;
      prog_code <= 8'h00;
    end else if (prog_wr) begin
      prog_end  <= 1'b1;
      prog_code <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder. A queue-based behavioural model of the
//   responder is updated on each rising edge and compared against the DUT on
//   each falling edge; literal expectations along the directed sequence pin
//   the model to hand-computed values.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic        load_we;
  logic [16:0] load_addr;
  logic [7:0]  load_data;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_end;
  logic [7:0]  prog_code;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  mem_responder #(
    .ADDR_WIDTH (17),
    .FIFO_DEPTH (16),
    .FULL_MARGIN(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_a         (cpu_a),
    .cpu_wr        (cpu_wr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .io_buffer_full(io_buffer_full),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .prog_end      (prog_end),
    .prog_code     (prog_code),
    .tx_overflow   (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drive one CPU access for one full cycle; returns just after the next
  // falling edge, when the registered results of that access are visible.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                               input logic [7:0] wdata);
    cpu_a     = addr;
    cpu_wr    = wr;
    cpu_wdata = wdata;
    @(negedge clk);
    #1;
  endtask

  // Behavioural model: sparse RAM plus two byte queues.
  logic [7:0] ram_m [int];
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  logic [7:0] exp_rdata;
  bit         exp_rdata_known;
  bit         exp_prog_end;
  logic [7:0] exp_prog_code;
  bit         exp_ovf;
  bit         model_ready = 1'b0;

  always @(posedge clk) begin : model
    bit          io;
    logic [15:0] off;
    bit          pre_tx_full;
    bit          pre_rx_ne;
    bit          do_tx_pop;
    bit          do_tx_push;
    bit          do_rx_push;
    int          idx;
    if (load_we) ram_m[int'(load_addr)] = load_data;
    if (rst) begin
      rx_q.delete();
      tx_q.delete();
      exp_rdata       = 8'h00;
      exp_rdata_known = 1'b1;
      exp_prog_end    = 1'b0;
      exp_prog_code   = 8'h00;
      exp_ovf         = 1'b0;
      model_ready     = 1'b1;
    end else begin
      pre_tx_full = (tx_q.size() == 16);
      pre_rx_ne   = (rx_q.size() != 0);
      do_tx_pop   = (tx_q.size() != 0) && tx_ready;
      do_rx_push  = rx_valid && (rx_q.size() != 16);
      do_tx_push  = 1'b0;
      io  = (cpu_a[17:16] == 2'b11);
      off = cpu_a[15:0];
      idx = int'(cpu_a[16:0]);
      if (!load_we) begin
        exp_rdata_known = 1'b1;
        if (cpu_wr) begin
          exp_rdata = 8'h00;
          if (!io) begin
            ram_m[idx] = cpu_wdata;
          end else if (off == 16'h0000) begin
            if (pre_tx_full) exp_ovf = 1'b1;
            else do_tx_push = 1'b1;
          end else if (off == 16'h0004 && !exp_prog_end) begin
            exp_prog_end  = 1'b1;
            exp_prog_code = cpu_wdata;
          end
        end else begin
          if (!io) begin
            if (ram_m.exists(idx)) exp_rdata = ram_m[idx];
            else exp_rdata_known = 1'b0;
          end else if (off == 16'h0000) begin
            if (pre_rx_ne) begin
              exp_rdata = rx_q[0];
              rx_q.delete(0);
            end else begin
              exp_rdata = 8'h00;
            end
          end else if (off == 16'h0004) begin
            exp_rdata = {6'b0, pre_tx_full, pre_rx_ne};
          end else begin
            exp_rdata = 8'h00;
          end
        end
      end
      if (do_tx_pop)  tx_q.delete(0);
      if (do_tx_push) tx_q.push_back(cpu_wdata);
      if (do_rx_push) rx_q.push_back(rx_data);
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      if (exp_rdata_known) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
      checkOutput("rx_ready", 32'(rx_ready), 32'(rx_q.size() != 16));
      checkOutput("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      if (tx_q.size() != 0) checkOutput("tx_data", 32'(tx_data), 32'(tx_q[0]));
      checkOutput("io_buffer_full", 32'(io_buffer_full), 32'(tx_q.size() >= 14));
      checkOutput("prog_end", 32'(prog_end), 32'(exp_prog_end));
      checkOutput("prog_code", 32'(prog_code), 32'(exp_prog_code));
      checkOutput("tx_overflow", 32'(tx_overflow), 32'(exp_ovf));
    end
  end

  logic [7:0] drained [$];
  int         guard;

  initial begin
    rst = 1'b1;  load_we = 1'b0; load_addr = '0; load_data = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    cpu_a = 32'h0; cpu_wr = 1'b0; cpu_wdata = 8'h00;

    // Reset state
    applyStimulus(32'h0, 1'b0, 8'h00);
    applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'h1);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("rst_io_full", 32'(io_buffer_full), 32'h0);
    checkOutput("rst_prog_end", 32'(prog_end), 32'h0);
    checkOutput("rst_tx_overflow", 32'(tx_overflow), 32'h0);
    rst = 1'b0;

    // Loader preload; cpu_rdata holds while the loader owns the cycle
    load_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_addr = 17'(i);
      load_data = (i == 0) ? 8'h13 : 8'h00;
      applyStimulus(32'h0, 1'b0, 8'h00);
    end
    load_we = 1'b0;
    checkOutput("load_hold_rdata", 32'(cpu_rdata), 32'h00);
    applyStimulus(32'h0, 1'b0, 8'h00); checkOutput("rd0", 32'(cpu_rdata), 32'h13);
    applyStimulus(32'h1, 1'b0, 8'h00); checkOutput("rd1", 32'(cpu_rdata), 32'h00);
    applyStimulus(32'h2, 1'b0, 8'h00); checkOutput("rd2", 32'(cpu_rdata), 32'h00);
    applyStimulus(32'h3, 1'b0, 8'h00); checkOutput("rd3", 32'(cpu_rdata), 32'h00);

    // Top-of-RAM write, read-back and alias
    applyStimulus(32'h1FFFF, 1'b1, 8'hAB); checkOutput("wr_rdata_zero", 32'(cpu_rdata), 32'h00);
    applyStimulus(32'h1FFFF, 1'b0, 8'h00); checkOutput("rd_1ffff", 32'(cpu_rdata), 32'hAB);
    applyStimulus(32'h21FFFF, 1'b0, 8'h00); checkOutput("rd_alias", 32'(cpu_rdata), 32'hAB);

    // Host bytes into input FIFO
    rx_valid = 1'b1; rx_data = 8'h41; applyStimulus(32'h0, 1'b0, 8'h00);
    rx_data = 8'h42;                  applyStimulus(32'h0, 1'b0, 8'h00);
    rx_valid = 1'b0;
    applyStimulus(32'h30004, 1'b0, 8'h00); checkOutput("status_rx", 32'(cpu_rdata), 32'h01);
    applyStimulus(32'h30000, 1'b0, 8'h00); checkOutput("rx_pop0", 32'(cpu_rdata), 32'h41);
    applyStimulus(32'h30000, 1'b0, 8'h00); checkOutput("rx_pop1", 32'(cpu_rdata), 32'h42);
    applyStimulus(32'h30000, 1'b0, 8'h00); checkOutput("rx_pop_empty", 32'(cpu_rdata), 32'h00);
    applyStimulus(32'h30004, 1'b0, 8'h00); checkOutput("status_rx_empty", 32'(cpu_rdata), 32'h00);

    // Pop on empty with simultaneous push
    rx_valid = 1'b1; rx_data = 8'h55;
    applyStimulus(32'h30000, 1'b0, 8'h00); checkOutput("pop_empty_push", 32'(cpu_rdata), 32'h00);
    rx_valid = 1'b0;
    applyStimulus(32'h30004, 1'b0, 8'h00); checkOutput("status_after_pp", 32'(cpu_rdata), 32'h01);
    applyStimulus(32'h30000, 1'b0, 8'h00); checkOutput("rx_pop_55", 32'(cpu_rdata), 32'h55);

    // Fill the input FIFO past capacity, then drain
    rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'(8'h60 + i);
      applyStimulus(32'h0, 1'b0, 8'h00);
      if (i == 15) checkOutput("rx_full_ready", 32'(rx_ready), 32'h0);
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(32'h30000, 1'b0, 8'h00);
      if (i == 0)  checkOutput("rx_drain_first", 32'(cpu_rdata), 32'h60);
      if (i == 15) checkOutput("rx_drain_last", 32'(cpu_rdata), 32'h6F);
    end
    applyStimulus(32'h30000, 1'b0, 8'h00); checkOutput("rx_drained_empty", 32'(cpu_rdata), 32'h00);

    // Output FIFO: nearly-full threshold, full, overflow, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(32'h30000, 1'b1, 8'(8'h10 + i));
      if (i == 12) checkOutput("io_full_13", 32'(io_buffer_full), 32'h0);
      if (i == 13) checkOutput("io_full_14", 32'(io_buffer_full), 32'h1);
    end
    applyStimulus(32'h30000, 1'b1, 8'h1F);
    applyStimulus(32'h30004, 1'b0, 8'h00); checkOutput("status_tx_full", 32'(cpu_rdata), 32'h02);
    checkOutput("ovf_before", 32'(tx_overflow), 32'h0);
    applyStimulus(32'h30000, 1'b1, 8'h20); checkOutput("ovf_17th", 32'(tx_overflow), 32'h1);
    tx_ready = 1'b1;
    drained.delete();
    if (tx_valid) drained.push_back(tx_data);
    applyStimulus(32'h30000, 1'b1, 8'h21);
    guard = 0;
    while (tx_valid && guard < 40) begin
      drained.push_back(tx_data);
      applyStimulus(32'h0, 1'b0, 8'h00);
      guard++;
    end
    checkOutput("tx_drain_bound", 32'(tx_valid), 32'h0);
    checkOutput("tx_drain_count", 32'(drained.size()), 32'd16);
    if (drained.size() == 16) begin
      checkOutput("tx_drain_first", 32'(drained[0]), 32'h10);
      checkOutput("tx_drain_last", 32'(drained[15]), 32'h1F);
    end
    checkOutput("ovf_sticky", 32'(tx_overflow), 32'h1);

    // Program-end register
    applyStimulus(32'h30004, 1'b1, 8'h00);
    checkOutput("prog_end_set", 32'(prog_end), 32'h1);
    checkOutput("prog_code_set", 32'(prog_code), 32'h00);
    applyStimulus(32'h30004, 1'b1, 8'h05);
    checkOutput("prog_code_keep", 32'(prog_code), 32'h00);
    applyStimulus(32'h30008, 1'b1, 8'h77);
    applyStimulus(32'h30008, 1'b0, 8'h00); checkOutput("io_other_rd", 32'(cpu_rdata), 32'h00);

    // Reset mid-traffic
    tx_ready = 1'b0;
    applyStimulus(32'h30000, 1'b1, 8'h31);
    applyStimulus(32'h30000, 1'b1, 8'h32);
    applyStimulus(32'h30000, 1'b1, 8'h33);
    applyStimulus(32'h100, 1'b1, 8'h5A);
    rx_valid = 1'b1; rx_data = 8'h99;
    applyStimulus(32'h100, 1'b0, 8'h00); checkOutput("pre_rst_rd", 32'(cpu_rdata), 32'h5A);
    rx_valid = 1'b0; tx_ready = 1'b1;
    applyStimulus(32'h0, 1'b0, 8'h00);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    load_we = 1'b1; load_addr = 17'h200; load_data = 8'hC3;
    applyStimulus(32'h30000, 1'b1, 8'h44);
    checkOutput("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    checkOutput("mid_rst_rdata", 32'(cpu_rdata), 32'h00);
    checkOutput("mid_rst_prog_end", 32'(prog_end), 32'h0);
    checkOutput("mid_rst_ovf", 32'(tx_overflow), 32'h0);
    rst = 1'b0; load_we = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    applyStimulus(32'h100, 1'b0, 8'h00); checkOutput("post_rst_ram", 32'(cpu_rdata), 32'h5A);
    applyStimulus(32'h200, 1'b0, 8'h00); checkOutput("post_rst_load", 32'(cpu_rdata), 32'hC3);
    applyStimulus(32'h30004, 1'b0, 8'h00); checkOutput("post_rst_status", 32'(cpu_rdata), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
